// File: rtl/mux_arbitrado_pkg.sv
// Shared definitions for the arbitrated N:1 selector: mode codes, output-register states
// and the select-width helper.
package mux_arbitrado_pkg;

  localparam int unsigned MODO_DIRETO     = 0;
  localparam int unsigned MODO_PRIORIDADE = 1;
  localparam int unsigned MODO_RODIZIO    = 2;

  typedef enum logic {
    VAZIO = 1'b0,
    CHEIO = 1'b1
  } estado_t;

  // Width of a channel index; never below one bit.
  function automatic int unsigned sel_largura(input int unsigned canais);
    return (canais > 2) ? $clog2(canais) : 1;
  endfunction

endpackage

// File: rtl/mux_arbitrado_arbitro_rodizio.sv
// Rotating-start first-valid search. It becomes a fixed-priority arbiter when ponteiro is tied to 0.
module arbitro_rodizio
  import mux_arbitrado_pkg::*;
#(
  parameter  int unsigned CANAIS = 4,
  localparam int unsigned SELW   = sel_largura(CANAIS)
) (
  input  logic [CANAIS-1:0] valido,
  input  logic [SELW-1:0]   ponteiro,
  input  logic              habilita,
  output logic [CANAIS-1:0] concessao,
  output logic [SELW-1:0]   indice,
  output logic              achou
);

  int unsigned idx;

  // Walk from ponteiro upward, wrap once, and keep the first requester found.
  always_comb begin
    concessao = '0;
    indice    = '0;
    achou     = 1'b0;
    idx       = 0;
    if (habilita) begin
      for (int unsigned k = 0; k < CANAIS; k++) begin
        idx = 32'(ponteiro) + k;
        if (idx >= CANAIS) begin
          idx = idx - CANAIS;
        end
        if (!achou && valido[SELW'(idx)]) begin
          achou                  = 1'b1;
          indice                 = SELW'(idx);
          concessao[SELW'(idx)]  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mux_arbitrado.sv
// N:1 selector with a valid/ready handshake on every channel. It offers direct, fixed-priority and
// round-robin selection and has a one-entry registered output with backpressure.
module mux_arbitrado
  import mux_arbitrado_pkg::*;
#(
  parameter  int unsigned WIDTH  = 8,
  parameter  int unsigned CANAIS = 4,
  parameter  int unsigned MODO   = MODO_DIRETO,
  localparam int unsigned SELW   = sel_largura(CANAIS)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [SELW-1:0]         controle,
  input  logic [CANAIS*WIDTH-1:0] entrada,
  input  logic [CANAIS-1:0]       valido,
  output logic [CANAIS-1:0]       pronto,
  output logic [WIDTH-1:0]        saida,
  output logic                    saida_valida,
  input  logic                    saida_pronta,
  output logic [SELW-1:0]         canal_sel
);

  logic [WIDTH-1:0]  canais [CANAIS];
  estado_t           estado, estado_prox;
  logic [SELW-1:0]   ponteiro, ptr_arb, indice_arb, g;
  logic [CANAIS-1:0] conc_arb, concessao;
  logic              achou_arb, tem_grant, livre, habilita, controle_ok;

  for (genvar i = 0; i < CANAIS; i++) begin : g_canal
    assign canais[i] = entrada[i*WIDTH +: WIDTH];
  end

  assign saida_valida = (estado == CHEIO);
  assign livre        = !saida_valida || saida_pronta;
  assign habilita     = reset && livre;
  assign ptr_arb      = (MODO == MODO_RODIZIO) ? ponteiro : '0;
  assign controle_ok  = 32'(controle) < CANAIS;

  arbitro_rodizio #(.CANAIS(CANAIS)) u_arbitro (
    .valido    (valido),
    .ponteiro  (ptr_arb),
    .habilita  (habilita),
    .concessao (conc_arb),
    .indice    (indice_arb),
    .achou     (achou_arb)
  );

  // Any mode code other than direct or round-robin falls back to the priority arbiter.
  always_comb begin
    concessao = '0;
    g         = '0;
    tem_grant = 1'b0;
    if (MODO == MODO_DIRETO) begin
      if (habilita && controle_ok && valido[controle]) begin
        concessao[controle] = 1'b1;
        g                   = controle;
        tem_grant           = 1'b1;
      end
    end else begin
      concessao = conc_arb;
      g         = indice_arb;
      tem_grant = achou_arb;
    end
  end

  assign pronto = concessao;

  always_ff @(posedge clock) begin
    if (!reset) begin
      estado <= VAZIO;
    end else begin
      estado <= estado_prox;
    end
  end

  // A full register empties only when the consumer takes the word and no new word replaces it.
  always_comb begin
    estado_prox = estado;
    case (estado)
      VAZIO:   if (tem_grant) estado_prox = CHEIO;
      CHEIO:   if (saida_pronta) estado_prox = tem_grant ? CHEIO : VAZIO;
      default: estado_prox = VAZIO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      saida     <= '0;
      canal_sel <= '0;
      ponteiro  <= '0;
    end else if (tem_grant) begin
      saida     <= canais[g];
      canal_sel <= g;
      if (MODO == MODO_RODIZIO) begin
        ponteiro <= (32'(g) == CANAIS - 1) ? '0 : g + SELW'(1);
      end
    end
  end

endmodule

// File: tb/tb_mux_arbitrado.sv
// Scoreboard bench for mux_arbitrado. It runs one instance per mode code (including an unknown code)
// on shared stimulus and checks them against a queue-based reference model.
module tb_mux_arbitrado;

  localparam int N  = 4;
  localparam int NM = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  controle = '0;
  logic [31:0] entrada = '0;
  logic [3:0]  valido = '0;
  logic        saida_pronta = 1'b1;

  logic [3:0]  pronto [NM];
  logic [7:0]  saida [NM];
  logic        saida_valida [NM];
  logic [1:0]  canal_sel [NM];

  typedef struct {
    int dado;
    int canal;
  } item_t;

  item_t fila [NM][$];
  int    ptr [NM];
  logic  prev_v [NM];
  int    total = 0;
  int    bad = 0;

  always #5 clock = ~clock;

  for (genvar m = 0; m < NM; m++) begin : g_dut
    mux_arbitrado #(.WIDTH(8), .CANAIS(4), .MODO(m)) u_dut (
      .clock        (clock),
      .reset        (reset),
      .controle     (controle),
      .entrada      (entrada),
      .valido       (valido),
      .pronto       (pronto[m]),
      .saida        (saida[m]),
      .saida_valida (saida_valida[m]),
      .saida_pronta (saida_pronta),
      .canal_sel    (canal_sel[m])
    );
  end

  task automatic chk(input string nome, input int m, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut=%0d got=%0h want=%0h t=%0t", nome, m, act, exp, $time);
    end
  endtask

  // Reference arbitration rules: -1 means that no channel is granted this cycle.
  function automatic int modelo_grant(input int m, input bit livre);
    int i;
    if (!reset || !livre) return -1;
    if (m == 0) return valido[controle] ? int'(controle) : -1;
    for (int k = 0; k < N; k++) begin
      i = (m == 2) ? (ptr[m] + k) % N : k;
      if (valido[i]) return i;
    end
    return -1;
  endfunction

  task automatic modelo_passo();
    bit cheio, livre;
    int g;
    for (int m = 0; m < NM; m++) begin
      cheio = fila[m].size() > 0;
      livre = !cheio || saida_pronta;
      g = modelo_grant(m, livre);
      chk("pronto", m, 32'(pronto[m]), (g >= 0) ? (32'd1 << g) : 32'd0);
      if (!reset) begin
        fila[m].delete();
        ptr[m] = 0;
      end else if (g >= 0) begin
        fila[m].push_back('{dado: int'((entrada >> (8 * g)) & 32'hFF), canal: g});
        if (m == 2) ptr[m] = (g + 1) % N;
      end
    end
  endtask

  // The caller drives inputs just after a falling edge. The model evaluates them before the next rising edge.
  task automatic ciclo();
    #2;
    modelo_passo();
    @(posedge clock);
    @(negedge clock);
    #1;
  endtask

  // Monitor: retire the word the consumer took at the last edge, then check the presented word against the scoreboard head.
  initial begin
    for (int m = 0; m < NM; m++) prev_v[m] = 1'b0;
    forever begin
      @(negedge clock);
      for (int m = 0; m < NM; m++) begin
        if (reset && prev_v[m] && saida_pronta && fila[m].size() > 0) void'(fila[m].pop_front());
        chk("saida_valida", m, 32'(saida_valida[m]), (fila[m].size() > 0) ? 32'd1 : 32'd0);
        if (saida_valida[m] === 1'b1 && fila[m].size() > 0) begin
          chk("saida", m, 32'(saida[m]), 32'(fila[m][0].dado));
          chk("canal_sel", m, 32'(canal_sel[m]), 32'(fila[m][0].canal));
        end
        prev_v[m] = saida_valida[m];
      end
    end
  end

  initial begin
    for (int m = 0; m < NM; m++) ptr[m] = 0;

    // Reset held with every channel requesting.
    reset = 1'b0; valido = 4'b1111; entrada = 32'hDEADBEEF;
    for (int c = 0; c < 3; c++) ciclo();
    for (int m = 0; m < NM; m++) begin
      chk("rst_saida", m, 32'(saida[m]), 32'd0);
      chk("rst_canal", m, 32'(canal_sel[m]), 32'd0);
      chk("rst_valida", m, 32'(saida_valida[m]), 32'd0);
    end

    // Direct selection of channel 2, then of an idle channel 3.
    reset = 1'b1; controle = 2'd2; valido = 4'b0100; entrada = 32'h11A5_2233; saida_pronta = 1'b1;
    ciclo();
    chk("dir_saida", 0, 32'(saida[0]), 32'hA5);
    chk("dir_canal", 0, 32'(canal_sel[0]), 32'd2);
    controle = 2'd3;
    ciclo();
    chk("dir_drop", 0, 32'(saida_valida[0]), 32'd0);

    // Fixed priority with channels 1 and 3 requesting.
    valido = 4'b1010;
    for (int c = 0; c < 4; c++) begin
      entrada = $urandom;
      ciclo();
      chk("pri_canal", 1, 32'(canal_sel[1]), 32'd1);
    end

    // Round-robin restart from channel 0, full load, wrap, then a sparse request pattern.
    reset = 1'b0; ciclo(); reset = 1'b1;
    valido = 4'b1111;
    for (int c = 0; c < 6; c++) begin
      entrada = $urandom;
      ciclo();
      chk("rr_seq", 2, 32'(canal_sel[2]), 32'(c % 4));
    end
    valido = 4'b1001;
    ciclo();
    chk("rr_sparse_a", 2, 32'(canal_sel[2]), 32'd3);
    ciclo();
    chk("rr_sparse_b", 2, 32'(canal_sel[2]), 32'd0);

    // Backpressure on a held 3C word, then a consume and a refill in the same cycle.
    valido = 4'b0001; controle = 2'd0; entrada = 32'h4433_2A3C;
    ciclo();
    saida_pronta = 1'b0; valido = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      entrada = $urandom;
      ciclo();
      for (int m = 0; m < NM; m++) begin
        chk("bp_saida", m, 32'(saida[m]), 32'h3C);
        chk("bp_pronto", m, 32'(pronto[m]), 32'd0);
      end
    end
    saida_pronta = 1'b1;
    ciclo();
    for (int m = 0; m < NM; m++) chk("swap_valida", m, 32'(saida_valida[m]), 32'd1);

    // Reset in the middle of a round-robin stream.
    valido = 4'b1111;
    ciclo(); ciclo();
    reset = 1'b0;
    ciclo();
    chk("rst_mid_valida", 2, 32'(saida_valida[2]), 32'd0);
    reset = 1'b1;
    ciclo();
    chk("rst_mid_canal", 2, 32'(canal_sel[2]), 32'd0);

    // Random traffic with occasional resets and consumer stalls.
    for (int c = 0; c < 400; c++) begin
      valido = 4'($urandom);
      controle = 2'($urandom_range(0, 3));
      entrada = $urandom;
      saida_pronta = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 49) != 0);
      ciclo();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
